// File: rtl/muldiv_sequencer.sv
// Iterative radix-2 multiply/divide unit owning the Hi/Lo register pair.
// One shift-add (multiply) or restoring shift-subtract (divide) step per clock.
// A final one-cycle step fixes up the signs and loads Hi/Lo.
module muldiv_sequencer #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic             clk,
    input  logic             Reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             hilo_rd,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             stall,
    output logic             div_zero
);

    localparam logic [CNT_W-1:0] CntInit = CNT_W'(WIDTH);

    typedef enum logic [1:0] {StIdle, StCalc, StSign} state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               is_div_q, is_div_d;
    logic               sign_a_q, sign_a_d;
    logic               sign_b_q, sign_b_d;
    // Multiply: multiplicand. Divide: divisor.
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    // Multiply: upper product half. Divide: partial remainder (one guard bit).
    logic [WIDTH:0]     acc_q, acc_d;
    // Multiply: multiplier shifting out / product low half shifting in.
    // Divide: dividend shifting out / quotient shifting in.
    logic [WIDTH-1:0]   low_q, low_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               dz_q, dz_d;

    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   a_abs, b_abs;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_sh;
    logic [WIDTH:0]     div_diff;
    logic [2*WIDTH-1:0] prod, prod_s;
    logic [WIDTH-1:0]   quot_s, rem_s;

    // Operand conditioning and per-step datapath arithmetic.
    always_comb begin
        a_neg    = op[0] & src_a[WIDTH-1];
        b_neg    = op[0] & src_b[WIDTH-1];
        a_abs    = a_neg ? (~src_a + 1'b1) : src_a;
        b_abs    = b_neg ? (~src_b + 1'b1) : src_b;
        mul_sum  = {1'b0, acc_q[WIDTH-1:0]} + (low_q[0] ? {1'b0, opnd_q} : '0);
        div_sh   = {acc_q[WIDTH-1:0], low_q[WIDTH-1]};
        div_diff = div_sh - {1'b0, opnd_q};
        prod     = {acc_q[WIDTH-1:0], low_q};
        prod_s   = (sign_a_q ^ sign_b_q) ? (~prod + 1'b1) : prod;
        quot_s   = (sign_a_q ^ sign_b_q) ? (~low_q + 1'b1) : low_q;
        // Remainder takes the dividend's sign.
        rem_s    = sign_a_q ? (~acc_q[WIDTH-1:0] + 1'b1) : acc_q[WIDTH-1:0];
    end

    // Next-state logic for the sequencer and the architectural Hi/Lo pair.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        is_div_d = is_div_q;
        sign_a_d = sign_a_q;
        sign_b_d = sign_b_q;
        opnd_d   = opnd_q;
        acc_d    = acc_q;
        low_d    = low_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        dz_d     = dz_q;

        unique case (state_q)
            StIdle: begin
                if (hi_we) hi_d = wr_data;
                if (lo_we) lo_d = wr_data;
                if (start) begin
                    is_div_d = op[1];
                    sign_a_d = a_neg;
                    sign_b_d = b_neg;
                    acc_d    = '0;
                    opnd_d   = op[1] ? b_abs : a_abs;
                    low_d    = op[1] ? a_abs : b_abs;
                    cnt_d    = CntInit;
                    busy_d   = 1'b1;
                    state_d  = StCalc;
                    if (op[1] && (src_b == '0)) dz_d = 1'b1;
                end
            end
            StCalc: begin
                if (is_div_q) begin
                    // Restoring step: keep the shifted remainder if the trial subtract underflows.
                    if (!div_diff[WIDTH]) acc_d = div_diff;
                    else                  acc_d = div_sh;
                    low_d = {low_q[WIDTH-2:0], ~div_diff[WIDTH]};
                end else begin
                    acc_d = {1'b0, mul_sum[WIDTH:1]};
                    low_d = {mul_sum[0], low_q[WIDTH-1:1]};
                end
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) state_d = StSign;
            end
            StSign: begin
                if (is_div_q) begin
                    hi_d = rem_s;
                    lo_d = quot_s;
                end else begin
                    hi_d = prod_s[2*WIDTH-1:WIDTH];
                    lo_d = prod_s[WIDTH-1:0];
                end
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = StIdle;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = StIdle;
            end
        endcase
    end

    // State registers; reset wins over any in-flight op or simultaneous command.
    always_ff @(posedge clk) begin
        if (!Reset) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            is_div_q <= 1'b0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            opnd_q   <= '0;
            acc_q    <= '0;
            low_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            dz_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            is_div_q <= is_div_d;
            sign_a_q <= sign_a_d;
            sign_b_q <= sign_b_d;
            opnd_q   <= opnd_d;
            acc_q    <= acc_d;
            low_q    <= low_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            dz_q     <= dz_d;
        end
    end

    assign hi       = hi_q;
    assign lo       = lo_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign div_zero = dz_q;
    // Any Hi/Lo consumer or new command must wait while an op is running.
    assign stall    = busy_q & (start | hilo_rd | hi_we | lo_we);

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Bench for muldiv_sequencer: arithmetic reference model plus directed vectors.
module tb_muldiv_sequencer;
    localparam int W = 32;

    logic          clk = 1'b0;
    logic          Reset;
    logic          start;
    logic [1:0]    op;
    logic [W-1:0]  src_a, src_b;
    logic          hi_we, lo_we;
    logic [W-1:0]  wr_data;
    logic          hilo_rd;
    logic [W-1:0]  hi, lo;
    logic          busy, done, stall, div_zero;

    always #5 clk = ~clk;

    muldiv_sequencer #(.WIDTH(W), .CNT_W(6)) dut (
        .clk(clk), .Reset(Reset), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
        .hi_we(hi_we), .lo_we(lo_we), .wr_data(wr_data), .hilo_rd(hilo_rd),
        .hi(hi), .lo(lo), .busy(busy), .done(done), .stall(stall), .div_zero(div_zero)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference result {hi, lo} from plain arithmetic.
    function automatic logic [63:0] model_result(input logic [1:0] o, input logic [31:0] a,
                                                 input logic [31:0] b);
        longint sa, sb, p, q, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (o)
            2'b00: return {32'b0, a} * {32'b0, b};
            2'b01: begin
                p = sa * sb;
                return p;
            end
            2'b10: begin
                if (b == 0) return {a, 32'hffffffff};
                return {a % b, a / b};
            end
            default: begin
                // Unguarded datapath: quotient all ones, remainder |a|, then sign fix-up.
                if (b == 0) return {a, (a[31] ? 32'h1 : 32'hffffffff)};
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
        endcase
    endfunction

    // Model state: cycles remaining until the pending result lands.
    logic [31:0] m_hi = '0, m_lo = '0, r_hi = '0, r_lo = '0;
    bit          m_done = 0, m_dz = 0, cmp_en = 0;
    int          m_rem = 0;

    always @(posedge clk) begin
        if (!Reset) begin
            m_hi = '0; m_lo = '0; m_done = 0; m_dz = 0; m_rem = 0;
        end else begin
            m_done = 0;
            if (m_rem > 0) begin
                m_rem--;
                if (m_rem == 0) begin
                    m_hi = r_hi; m_lo = r_lo; m_done = 1;
                end
            end else begin
                if (hi_we) m_hi = wr_data;
                if (lo_we) m_lo = wr_data;
                if (start) begin
                    {r_hi, r_lo} = model_result(op, src_a, src_b);
                    m_rem = W + 1;
                    if (op[1] && src_b == 0) m_dz = 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("m_busy", busy, m_rem != 0);
            chk("m_done", done, m_done);
            chk("m_hi", hi, m_hi);
            chk("m_lo", lo, m_lo);
            chk("m_div_zero", div_zero, m_dz);
            chk("m_stall", stall, (m_rem != 0) && (start || hilo_rd || hi_we || lo_we));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Issue one op in the current cycle (cycle 0) and follow it to cycle W+2.
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] eh, input logic [31:0] el, input bit hw,
                          input logic [31:0] wd, input int rd_from, input bit spur);
        start = 1; op = o; src_a = a; src_b = b; hi_we = hw; wr_data = wd; hilo_rd = 0;
        cyc();
        start = 0; hi_we = 0;
        if (hw) chk("write_first", hi, wd);
        for (int k = 1; k <= W + 2; k++) begin
            hilo_rd = (rd_from != 0) && (k >= rd_from);
            if (spur && (k == 5 || k == 6)) begin
                start = 1; op = 2'b00; src_a = 9; src_b = 9; hi_we = 1; wr_data = 32'hdead;
            end else if (spur && k == 7) begin
                start = 0; hi_we = 0;
            end
            #1;
            chk("busy_window", busy, k <= W + 1);
            chk("done_window", done, k == W + 2);
            if (rd_from != 0 && k >= rd_from) chk("rd_stall", stall, k <= W + 1);
            if (spur && (k == 5 || k == 6)) chk("spur_stall", stall, 1);
            if (k < W + 2) cyc();
        end
        chk("result_hi", hi, eh);
        chk("result_lo", lo, el);
    endtask

    initial begin
        Reset = 0; start = 1; op = 2'b11; src_a = 32'h1234_5678; src_b = 32'h0;
        hi_we = 1; lo_we = 1; wr_data = 32'hffff_0000; hilo_rd = 1;
        repeat (3) @(posedge clk);
        #1;
        Reset = 1; start = 0; op = 0; src_a = 0; src_b = 0;
        hi_we = 0; lo_we = 0; wr_data = 0; hilo_rd = 0;
        cmp_en = 1;
        chk("rst_hi", hi, 0);
        chk("rst_lo", lo, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_stall", stall, 0);
        chk("rst_div_zero", div_zero, 0);

        hilo_rd = 1; #1;
        chk("idle_rd_no_stall", stall, 0);
        hilo_rd = 0;

        hi_we = 1; wr_data = 32'h1234; cyc(); hi_we = 0;
        chk("mthi", hi, 32'h1234);
        lo_we = 1; wr_data = 32'h5678; cyc(); lo_we = 0;
        chk("mtlo", lo, 32'h5678);

        run_op(2'b01, 32'hffff_fffd, 32'd5, 32'hffff_ffff, 32'hffff_fff1, 0, 0, 0, 0);
        run_op(2'b00, 32'hffff_ffff, 32'd2, 32'h1, 32'hffff_fffe, 0, 0, 0, 0);
        run_op(2'b11, 32'hffff_fff9, 32'd2, 32'hffff_ffff, 32'hffff_fffd, 0, 0, 0, 0);
        run_op(2'b10, 32'd100, 32'd7, 32'd2, 32'd14, 0, 0, 0, 0);
        run_op(2'b11, 32'h8000_0000, 32'hffff_ffff, 32'h0, 32'h8000_0000, 0, 0, 0, 0);
        run_op(2'b00, 32'd3, 32'd4, 32'h0, 32'd12, 1, 32'habcd, 0, 0);
        run_op(2'b01, 32'hffff_fffd, 32'd5, 32'hffff_ffff, 32'hffff_fff1, 0, 0, 10, 0);
        hilo_rd = 0;
        run_op(2'b01, 32'd7, 32'd6, 32'h0, 32'd42, 0, 0, 0, 1);
        chk("dz_clear", div_zero, 0);
        run_op(2'b10, 32'd5, 32'd0, 32'd5, 32'hffff_ffff, 0, 0, 0, 0);
        chk("dz_set", div_zero, 1);
        run_op(2'b01, 32'hffff_fff9, 32'd6, 32'hffff_ffff, 32'hffff_ffd6, 0, 0, 0, 0);
        chk("dz_sticky", div_zero, 1);

        // Abort mid-op with a simultaneous start.
        start = 1; op = 2'b01; src_a = 32'd7; src_b = 32'd6;
        cyc();
        start = 0;
        for (int k = 1; k < 20; k++) cyc();
        Reset = 0; start = 1; op = 2'b00; src_a = 3; src_b = 3;
        cyc();
        Reset = 1; start = 0;
        chk("abort_busy", busy, 0);
        chk("abort_hi", hi, 0);
        chk("abort_lo", lo, 0);
        chk("abort_dz", div_zero, 0);
        for (int k = 0; k < 40; k++) begin
            chk("abort_no_done", done, 0);
            cyc();
        end

        cmp_en = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
